// File: rtl/window_seq_pkg.sv
// Shared types and default geometry for the sample-window sequencer.
package window_seq_pkg;

  localparam int SAMPLES_SIZE_DEF = 64;
  localparam int ADDR_W_DEF       = 6;
  localparam int HOP_DEF          = 16;
  localparam int OVR_W            = 8;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_STREAM = 2'd2,
    ST_WAIT   = 2'd3
  } state_e;

  // Saturating increment for the overrun counter
  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    logic [OVR_W-1:0] r;
    if (v == {OVR_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(OVR_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Window read-address generator: latches the oldest slot and walks all
// SAMPLES_SIZE indices, advancing only when the consumer accepts.
module window_addr_gen
  import window_seq_pkg::*;
#(
  parameter int SAMPLES_SIZE = SAMPLES_SIZE_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stream_i,
  input  logic              ready_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              first_o,
  output logic              last_o,
  output logic              last_accept_o
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] k_q, k_d;

  // Base latch and k counter next-state
  always_comb begin
    base_d = base_q;
    k_d    = k_q;
    if (start_i) begin
      base_d = base_i;
      k_d    = '0;
    end else if (stream_i && ready_i) begin
      k_d = k_q + ADDR_W'(1);
    end else begin
      k_d = k_q;
    end
  end

  // Base and k registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q <= '0;
      k_q    <= '0;
    end else begin
      base_q <= base_d;
      k_q    <= k_d;
    end
  end

  // Index decode; natural wrap of base + k gives the circular walk
  always_comb begin
    idx_o         = '0;
    first_o       = 1'b0;
    last_o        = 1'b0;
    last_accept_o = 1'b0;
    if (stream_i) begin
      idx_o         = base_q + k_q;
      first_o       = (k_q == '0);
      last_o        = (k_q == ADDR_W'(SAMPLES_SIZE - 1));
      last_accept_o = ready_i && (k_q == ADDR_W'(SAMPLES_SIZE - 1));
    end else begin
      idx_o         = '0;
      first_o       = 1'b0;
      last_o        = 1'b0;
      last_accept_o = 1'b0;
    end
  end

endmodule

// File: rtl/window_seq.sv
// Sample-window sequencer: forwards sample strobes, tracks fill/hop, gates
// jobs on window energy and streams the buffer to a downstream consumer.
module window_seq
  import window_seq_pkg::*;
#(
  parameter int SAMPLES_SIZE = SAMPLES_SIZE_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int HOP          = HOP_DEF
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                sample_valid_in,
  output logic                sampler_ready_out,
  input  logic [ADDR_W-1:0]   offset_in,
  input  logic signed [31:0]  norm_in,
  input  logic signed [31:0]  threshold_in,
  output logic [ADDR_W-1:0]   rd_idx_out,
  output logic                rd_valid_out,
  output logic                rd_first_out,
  output logic                rd_last_out,
  input  logic                consumer_ready_in,
  input  logic                job_done_in,
  output logic                done_out,
  output logic                stale_out,
  output logic                gate_skip_out,
  output logic                full_out,
  output logic                busy_out,
  output logic [OVR_W-1:0]    overrun_count_out
);

  localparam int FILL_W = $clog2(SAMPLES_SIZE + 1);
  localparam int HOP_W  = $clog2(HOP);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SAMPLES_SIZE);
  localparam logic [HOP_W-1:0]  HOP_LAST = HOP_W'(HOP - 1);

  state_e            state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [HOP_W-1:0]  hop_q, hop_d;
  logic              pend_q, pend_d;
  logic              smp_rdy_q;
  logic              stale_acc_q, stale_acc_d;
  logic [OVR_W-1:0]  ovr_q, ovr_d;
  logic              done_q, done_d;
  logic              stale_q, stale_d;
  logic              gate_skip_q, gate_skip_d;
  logic              rd_valid_q, busy_q, full_q;
  logic              start_s, stream_s, last_accept_s;

  assign stream_s = (state_q == ST_STREAM);

  window_addr_gen #(
    .SAMPLES_SIZE (SAMPLES_SIZE),
    .ADDR_W       (ADDR_W)
  ) u_addr_gen (
    .clk_i         (clk_in),
    .rst_i         (rst_in),
    .start_i       (start_s),
    .stream_i      (stream_s),
    .ready_i       (consumer_ready_in),
    .base_i        (offset_in),
    .idx_o         (rd_idx_out),
    .first_o       (rd_first_out),
    .last_o        (rd_last_out),
    .last_accept_o (last_accept_s)
  );

  // Counters, trigger pend, energy gate, overrun and FSM next-state
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    hop_d       = hop_q;
    pend_d      = 1'b0;
    ovr_d       = ovr_q;
    gate_skip_d = 1'b0;
    done_d      = 1'b0;
    stale_d     = 1'b0;
    stale_acc_d = stale_acc_q;
    start_s     = 1'b0;

    if (smp_rdy_q) begin
      fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
      hop_d  = (hop_q == HOP_LAST) ? '0 : hop_q + HOP_W'(1);
      pend_d = (hop_q == HOP_LAST) && (fill_d == FILL_MAX);
    end else begin
      pend_d = 1'b0;
    end

    case (state_q)
      ST_FILL: begin
        if (fill_d == FILL_MAX) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_IDLE: begin
        if (pend_q && (norm_in > threshold_in)) begin
          start_s     = 1'b1;
          stale_acc_d = 1'b0;
          state_d     = ST_STREAM;
        end else if (pend_q) begin
          gate_skip_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (pend_q) begin
          ovr_d = sat_inc(ovr_q);
        end else begin
          ovr_d = ovr_q;
        end
        if (smp_rdy_q) begin
          stale_acc_d = 1'b1;
        end else begin
          stale_acc_d = stale_acc_q;
        end
        if (last_accept_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_WAIT: begin
        if (pend_q) begin
          ovr_d = sat_inc(ovr_q);
        end else begin
          ovr_d = ovr_q;
        end
        if (job_done_in) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          stale_d = stale_acc_q;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_FILL;
      fill_q      <= '0;
      hop_q       <= '0;
      pend_q      <= 1'b0;
      smp_rdy_q   <= 1'b0;
      stale_acc_q <= 1'b0;
      ovr_q       <= '0;
      done_q      <= 1'b0;
      stale_q     <= 1'b0;
      gate_skip_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      hop_q       <= hop_d;
      pend_q      <= pend_d;
      smp_rdy_q   <= sample_valid_in;
      stale_acc_q <= stale_acc_d;
      ovr_q       <= ovr_d;
      done_q      <= done_d;
      stale_q     <= stale_d;
      gate_skip_q <= gate_skip_d;
      rd_valid_q  <= (state_d == ST_STREAM);
      busy_q      <= (state_d == ST_STREAM) || (state_d == ST_WAIT);
      full_q      <= (fill_d == FILL_MAX);
    end
  end

  assign sampler_ready_out = smp_rdy_q;
  assign rd_valid_out      = rd_valid_q;
  assign done_out          = done_q;
  assign stale_out         = stale_q;
  assign gate_skip_out     = gate_skip_q;
  assign full_out          = full_q;
  assign busy_out          = busy_q;
  assign overrun_count_out = ovr_q;

endmodule

// File: doc/window_seq.md
# window_seq

Sample-window sequencer for the 64-entry circular sample buffer and its running-energy (norm) output. It forwards audio-front-end sample strobes to the buffer and tracks the fill level. Every HOP new samples, once the buffer is full and the window energy exceeds a programmable threshold, it streams all 64 buffer indices oldest-to-newest to a downstream consumer (FIR/correlator MAC). It then waits for the consumer's completion before arming the next job.

## Interface
Parameters:
- SAMPLES_SIZE, 64, buffer depth; power of two; multiple of HOP
- ADDR_W, 6, log2(SAMPLES_SIZE)
- HOP, 16, samples between job triggers

Ports:
- clk_in  input  1  single system clock
- rst_in  input  1  reset, asynchronous, active-high
- sample_valid_in  input  1  one-cycle strobe: new audio sample presented to buffer
- sampler_ready_out  output  1  write strobe to buffer (registered copy of sample_valid_in)
- offset_in  input  ADDR_W  buffer write pointer (next slot to write = oldest entry)
- norm_in  input  32 signed  buffer running sum of squares
- threshold_in  input  32 signed  energy gate; job launches only if norm_in > threshold_in
- rd_idx_out  output  ADDR_W  buffer index for consumer
- rd_valid_out  output  1  rd_idx_out valid
- rd_first_out  output  1  first index of window
- rd_last_out  output  1  last index of window
- consumer_ready_in  input  1  consumer accepts index this cycle
- job_done_in  input  1  consumer finished job (one-cycle pulse)
- done_out  output  1  one-cycle pulse on job completion
- stale_out  output  1  valid with done_out: buffer written during streaming
- gate_skip_out  output  1  one-cycle pulse: trigger suppressed by energy gate
- full_out  output  1  buffer holds SAMPLES_SIZE valid samples
- busy_out  output  1  state is STREAM or WAIT
- overrun_count_out  output  8  triggers lost while busy; saturates at 255

## Operation
- States: FILL, IDLE, STREAM, WAIT. Reset state FILL.
- Forwarding: sample_valid_in at cycle t gives sampler_ready_out at t+1. Back-to-back strobes are all forwarded; forwarding happens in every state.
- fill_cnt (0..SAMPLES_SIZE) increments on each sampler_ready_out and saturates. full_out = (fill_cnt == SAMPLES_SIZE). FILL->IDLE when fill_cnt reaches SAMPLES_SIZE.
- hop_cnt (0..HOP-1) increments on each sampler_ready_out and wraps.
- Trigger: a forwarded sample at t+1 with hop_cnt == HOP-1 and buffer full after this write sets pend. With defaults, the 64th sample triggers.
- pend is evaluated at t+2, when offset_in and norm_in reflect the write. pend is then cleared:
  - IDLE and norm_in > threshold_in (signed compare): latch base = offset_in, k = 0, go STREAM.
  - IDLE and norm_in <= threshold_in: gate_skip_out pulse; stay IDLE.
  - STREAM or WAIT: overrun_count_out += 1, saturating.
- STREAM:
  - rd_valid_out = 1; rd_idx_out = base + k, mod 2^ADDR_W (natural wrap).
  - rd_first_out = (k == 0); rd_last_out = (k == SAMPLES_SIZE-1).
  - k advances only when consumer_ready_in = 1. The index is held stable while stalled.
  - The last accepted index moves the state to WAIT.
- WAIT: rd_valid_out = 0. On job_done_in, go IDLE and pulse done_out. stale_out = 1 if any sampler_ready_out occurred from STREAM entry through the last accepted index; stale_out = 0 otherwise.
- job_done_in outside WAIT is ignored.
- A job_done_in and a pend evaluation in the same cycle: the pend sees WAIT, counts as an overrun, and the state still goes IDLE.

## Timing
- Reset values: all outputs 0; state FILL; fill_cnt, hop_cnt, pend, base, k all 0.
- Reset mid-job aborts immediately: rd_valid_out drops asynchronously and the counters clear.
- Trigger-to-first-index latency: sample_valid_in at t gives rd_valid_out at t+3, with rd_first_out high and rd_idx_out = offset after the write.
- Stream length is SAMPLES_SIZE cycles with consumer_ready_in held high.
- done_out occurs in the cycle after job_done_in is sampled in WAIT. stale_out is valid in that same cycle only.
- All outputs are registered except rd_idx_out, rd_first_out and rd_last_out, which decode combinationally from registered base, k and state.

## Structure
- Package window_seq_pkg: state enum (FILL, IDLE, STREAM, WAIT), SAMPLES_SIZE, ADDR_W, HOP defaults, overrun counter width.
- Sub-module window_addr_gen: base latch, k counter with consumer_ready_in enable, rd_idx/first/last decode, last-accepted pulse.
- FSM, fill/hop counters, gate and overrun logic stay in window_seq.

## Test plan
- Reset, then 63 strobes with threshold_in = -1: full_out = 0, no rd_valid_out. The 64th strobe at t: full_out = 1 and rd_valid_out at t+3 with rd_idx_out = 0, rd_first_out = 1. Indices run 0..63; rd_last_out is high on 63.
- Full buffer, offset 37, consumer_ready_in toggling 1/0: indices 37..63, 0..36 appear in order, each held during stall. After job_done_in: done_out = 1, stale_out = 0.
- threshold_in = 1000, norm_in = 1000 at trigger: gate_skip_out pulse, no stream. With norm_in = 1001: stream starts.
- Trigger with job_done_in withheld, then 300 further HOP boundaries: overrun_count_out reaches 255 and holds. job_done_in then returns to IDLE.
- Sample strobe mid-stream (buffer write during STREAM): done_out with stale_out = 1.
- Assert rst_in mid-STREAM at k = 20: rd_valid_out = 0 immediately, state FILL, full_out = 0. The 64 samples after release retrigger normally.
